// File: rtl/rx78_pkg.sv
// Shared definitions for the RX-78 save/upload path: read-FSM states,
// the default upload index and the byte returned for unmapped reads.
package rx78_pkg;

  // Read-path FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2
  } rd_state_t;

  // ioctl_index used by hps_io for the save-RAM upload.
  localparam logic [7:0] UPLOAD_INDEX_DEFAULT = 8'd2;

  // Byte returned for reads beyond the end of the image and after reset.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Value loaded into the latency counter on accept. S_READ stays for
  // (value + 1) cycles, so the BRAM latency maps to latency - 1.
  function automatic logic [1:0] latency_load(input int latency);
    return 2'(latency - 1);
  endfunction

endpackage

// File: rtl/rx78_save_upload.sv
// RX-78 save-RAM upload engine. Serves hps_io byte reads from the second
// port of the EXT RAM BRAM, tracks whether the image is dirty, and asks
// the HPS to start an upload on a manual save or after an idle period.
module rx78_save_upload
  import rx78_pkg::*;
#(
  parameter int          ADDR_W         = 15,
  parameter int          DATA_BYTES     = 32768,
  parameter int          RAM_LATENCY    = 1,
  parameter logic [7:0]  UPLOAD_INDEX   = UPLOAD_INDEX_DEFAULT,
  parameter logic [23:0] AUTOSAVE_DELAY = 24'd10_000_000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ioctl_upload_req,
  input  logic              save_req,
  input  logic              autosave_en,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              dirty,
  output logic              busy
);

  // Counter value at which the autosave request fires, and its saturation point.
  localparam logic [23:0] AUTOSAVE_FIRE = AUTOSAVE_DELAY - 24'd2;
  localparam logic [23:0] AUTOSAVE_SAT  = AUTOSAVE_DELAY - 24'd1;
  localparam logic [1:0]  LAT_LOAD      = latency_load(RAM_LATENCY);

  // Read FSM state and registered outputs.
  rd_state_t         state_reg;
  logic [1:0]        lat_cnt_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_rd_reg;
  logic [7:0]        din_reg;
  logic              oor_reg;
  logic              last_reg;

  // Edge detectors.
  logic upload_d_reg;
  logic save_d_reg;

  // Image status.
  logic dirty_reg;
  logic full_reg;

  // Upload request generation.
  logic [23:0] autosave_cnt_reg;
  logic        pending_reg;
  logic        req_pulse_reg;

  // Request decode.
  logic accept;
  logic oor_now;
  logic last_now;
  logic upload_rise;
  logic upload_fall;
  logic save_rise;
  logic autosave_count_en;
  logic autosave_fire;
  logic req_src;

  // A new read is only taken while idle and only for our upload index.
  assign accept = !reset && ioctl_rd && ioctl_upload &&
                  (ioctl_index == UPLOAD_INDEX) && (state_reg == S_IDLE);

  // The range checks use the full 25-bit address so aliases above the
  // image never reach the BRAM.
  assign oor_now  = (ioctl_addr >= 25'(DATA_BYTES));
  assign last_now = (ioctl_addr == 25'(DATA_BYTES - 1));

  assign upload_rise = ioctl_upload && !upload_d_reg;
  assign upload_fall = !ioctl_upload && upload_d_reg;
  assign save_rise   = save_req && !save_d_reg;

  // The counter only advances while the image is dirty, the feature is
  // enabled, no upload is running and the CPU is not writing this cycle.
  assign autosave_count_en = dirty_reg && autosave_en && !ioctl_upload && !cpu_we;
  assign autosave_fire     = autosave_count_en && (autosave_cnt_reg == AUTOSAVE_FIRE);
  assign req_src           = save_rise || autosave_fire;

  // Wait covers the accept cycle combinationally, then follows the FSM.
  assign ioctl_wait       = accept || (state_reg != S_IDLE);
  assign busy             = (state_reg != S_IDLE);
  assign ioctl_din        = din_reg;
  assign ram_addr         = ram_addr_reg;
  assign ram_rd           = ram_rd_reg;
  assign dirty            = dirty_reg;
  assign ioctl_upload_req = req_pulse_reg;

  // Read FSM: accept, issue one BRAM read, wait out its latency, latch the byte.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      lat_cnt_reg  <= 2'd0;
      ram_addr_reg <= '0;
      ram_rd_reg   <= 1'b0;
      din_reg      <= FILL_BYTE;
      oor_reg      <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      ram_rd_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg    <= S_READ;
            ram_addr_reg <= ioctl_addr[ADDR_W-1:0];
            ram_rd_reg   <= !oor_now;
            oor_reg      <= oor_now;
            last_reg     <= last_now;
            lat_cnt_reg  <= LAT_LOAD;
          end
        end
        S_READ: begin
          if (lat_cnt_reg == 2'd0) begin
            state_reg <= S_LATCH;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 2'd1;
          end
        end
        S_LATCH: begin
          din_reg   <= oor_reg ? FILL_BYTE : ram_q;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Delayed copies of ioctl_upload and save_req for edge detection.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_d_reg <= 1'b0;
      save_d_reg   <= 1'b0;
    end else begin
      upload_d_reg <= ioctl_upload;
      save_d_reg   <= save_req;
    end
  end

  // Full flag: the last image byte has been served during this upload.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      full_reg <= 1'b0;
    end else if (upload_rise) begin
      full_reg <= 1'b0;
    end else if (state_reg == S_LATCH && last_reg) begin
      full_reg <= 1'b1;
    end
  end

  // Dirty flag: a CPU write wins over the clear at the end of a full upload.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty_reg <= 1'b0;
    end else if (cpu_we) begin
      dirty_reg <= 1'b1;
    end else if (upload_fall && full_reg) begin
      dirty_reg <= 1'b0;
    end
  end

  // Autosave idle counter: restarts on writes, holds during uploads, saturates.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      autosave_cnt_reg <= 24'd0;
    end else if (cpu_we || !dirty_reg || !autosave_en) begin
      autosave_cnt_reg <= 24'd0;
    end else if (!ioctl_upload && autosave_cnt_reg != AUTOSAVE_SAT) begin
      autosave_cnt_reg <= autosave_cnt_reg + 24'd1;
    end
  end

  // Upload request: defer while an upload runs, merge sources into one pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pending_reg   <= 1'b0;
      req_pulse_reg <= 1'b0;
    end else if (ioctl_upload) begin
      req_pulse_reg <= 1'b0;
      if (req_src) begin
        pending_reg <= 1'b1;
      end
    end else begin
      req_pulse_reg <= req_src || pending_reg;
      pending_reg   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx78_save_upload.sv
// Directed bench for rx78_save_upload: read timing, range handling,
// dirty tracking, autosave and manual save request generation, reset.
module tb_rx78_save_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic        save_req;
  logic        autosave_en;
  logic        cpu_we;
  logic [14:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        dirty;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:32767];

  always #5 clk_sys = ~clk_sys;

  rx78_save_upload #(
    .ADDR_W(15),
    .DATA_BYTES(32768),
    .RAM_LATENCY(1),
    .UPLOAD_INDEX(8'd2),
    .AUTOSAVE_DELAY(24'd100)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req),
    .save_req(save_req),
    .autosave_en(autosave_en),
    .cpu_we(cpu_we),
    .ram_addr(ram_addr),
    .ram_rd(ram_rd),
    .ram_q(ram_q),
    .dirty(dirty),
    .busy(busy)
  );

  // BRAM model with one cycle of read latency.
  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  // Move to just after the next rising edge.
  task automatic next_cyc;
    @(posedge clk_sys);
    #1;
  endtask

  // One read transaction observed over cycles T..T+3; optional second
  // ioctl_rd in T+1 that must be ignored.
  task automatic rd_txn(input logic [24:0] a, input logic [7:0] idx, input logic dbl,
                        output logic [3:0] wt, output logic [3:0] rt,
                        output logic [14:0] ra, output logic [7:0] d);
    ioctl_index = idx;
    ra = '0;
    d  = '0;
    for (int k = 0; k < 4; k++) begin
      ioctl_rd   = (k == 0) || (dbl && k == 1);
      ioctl_addr = (k == 0) ? a : 25'h0000010;
      @(negedge clk_sys);
      wt[k] = ioctl_wait;
      rt[k] = ram_rd;
      if (k == 1) ra = ram_addr;
      d = ioctl_din;
      next_cyc();
    end
    ioctl_rd = 1'b0;
    $display("rd addr=%h idx=%0d wait=%b ram_rd=%b ram_addr=%h din=%h", a, idx, wt, rt, ra, d);
  endtask

  task automatic test_reset;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
    ioctl_addr = '0; save_req = 1'b0; autosave_en = 1'b0; cpu_we = 1'b0;
    repeat (3) next_cyc();
    reset = 1'b0;
    @(negedge clk_sys);
    $display("reset din=%h wait=%b req=%b ram_rd=%b dirty=%b busy=%b ram_addr=%h",
             ioctl_din, ioctl_wait, ioctl_upload_req, ram_rd, dirty, busy, ram_addr);
    n_cmp++; if (ioctl_din !== 8'hFF) begin n_bad++; $display("FAIL reset_din got %h want ff", ioctl_din); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    n_cmp++; if (ioctl_upload_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", ioctl_upload_req); end
    n_cmp++; if (ram_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ram_rd got %b want 0", ram_rd); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("FAIL reset_dirty got %b want 0", dirty); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (ram_addr !== 15'h0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
    next_cyc();
  endtask

  task automatic test_read_inrange;
    logic [3:0] wt, rt; logic [14:0] ra; logic [7:0] d;
    ioctl_upload = 1'b1;
    next_cyc();
    rd_txn(25'h0000010, 8'd2, 1'b0, wt, rt, ra, d);
    n_cmp++; if (wt !== 4'b0111) begin n_bad++; $display("FAIL inrange_wait got %b want 0111", wt); end
    n_cmp++; if (rt !== 4'b0010) begin n_bad++; $display("FAIL inrange_ram_rd got %b want 0010", rt); end
    n_cmp++; if (ra !== 15'h0010) begin n_bad++; $display("FAIL inrange_ram_addr got %h want 0010", ra); end
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL inrange_din got %h want 5a", d); end
  endtask

  task automatic test_ignored;
    logic [3:0] wt, rt; logic [14:0] ra; logic [7:0] d;
    rd_txn(25'h0000020, 8'd1, 1'b0, wt, rt, ra, d);
    n_cmp++; if (wt !== 4'b0000) begin n_bad++; $display("FAIL idx1_wait got %b want 0000", wt); end
    n_cmp++; if (rt !== 4'b0000) begin n_bad++; $display("FAIL idx1_ram_rd got %b want 0000", rt); end
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL idx1_din got %h want 5a", d); end
    ioctl_upload = 1'b0;
    next_cyc();
    rd_txn(25'h0000020, 8'd2, 1'b0, wt, rt, ra, d);
    n_cmp++; if (wt !== 4'b0000) begin n_bad++; $display("FAIL noupload_wait got %b want 0000", wt); end
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL noupload_din got %h want 5a", d); end
  endtask

  task automatic test_read_oor;
    logic [3:0] wt, rt; logic [14:0] ra; logic [7:0] d;
    ioctl_upload = 1'b1;
    next_cyc();
    rd_txn(25'h0008000, 8'd2, 1'b1, wt, rt, ra, d);
    n_cmp++; if (wt !== 4'b0111) begin n_bad++; $display("FAIL oor_wait got %b want 0111", wt); end
    n_cmp++; if (rt !== 4'b0000) begin n_bad++; $display("FAIL oor_ram_rd got %b want 0000", rt); end
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL oor_din got %h want ff", d); end
    // Restore a known byte, then read an alias whose low bits are zero.
    rd_txn(25'h0000010, 8'd2, 1'b0, wt, rt, ra, d);
    rd_txn(25'h1000000, 8'd2, 1'b0, wt, rt, ra, d);
    n_cmp++; if (rt !== 4'b0000) begin n_bad++; $display("FAIL alias_ram_rd got %b want 0000", rt); end
    n_cmp++; if (d !== 8'hFF) begin n_bad++; $display("FAIL alias_din got %h want ff", d); end
  endtask

  task automatic test_dirty;
    logic [3:0] wt, rt; logic [14:0] ra; logic [7:0] d;
    ioctl_upload = 1'b0;
    next_cyc();
    cpu_we = 1'b1; next_cyc(); cpu_we = 1'b0;
    @(negedge clk_sys);
    $display("dirty after cpu_we=%b", dirty);
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("FAIL dirty_set got %b want 1", dirty); end
    next_cyc();
    // Full upload: last byte served, then upload drops.
    ioctl_upload = 1'b1; next_cyc();
    rd_txn(25'h0007FFE, 8'd2, 1'b0, wt, rt, ra, d);
    n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL rd_7ffe got %h want 3c", d); end
    rd_txn(25'h0007FFF, 8'd2, 1'b0, wt, rt, ra, d);
    n_cmp++; if (d !== 8'hC3) begin n_bad++; $display("FAIL rd_7fff got %h want c3", d); end
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("FAIL dirty_fall_cycle got %b want 1", dirty); end
    next_cyc();
    @(negedge clk_sys);
    $display("dirty after full upload=%b", dirty);
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("FAIL dirty_full_clear got %b want 0", dirty); end
    next_cyc();
    // Partial upload stopping short of the last byte.
    cpu_we = 1'b1; next_cyc(); cpu_we = 1'b0;
    ioctl_upload = 1'b1; next_cyc();
    rd_txn(25'h0007FFE, 8'd2, 1'b0, wt, rt, ra, d);
    ioctl_upload = 1'b0;
    next_cyc(); next_cyc();
    @(negedge clk_sys);
    $display("dirty after partial upload=%b", dirty);
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("FAIL dirty_partial got %b want 1", dirty); end
    next_cyc();
    // Full upload with a CPU write on the falling-edge cycle.
    ioctl_upload = 1'b1; next_cyc();
    rd_txn(25'h0007FFF, 8'd2, 1'b0, wt, rt, ra, d);
    ioctl_upload = 1'b0; cpu_we = 1'b1;
    next_cyc(); cpu_we = 1'b0;
    @(negedge clk_sys);
    $display("dirty after write on fall=%b", dirty);
    n_cmp++; if (dirty !== 1'b1) begin n_bad++; $display("FAIL dirty_we_on_fall got %b want 1", dirty); end
    next_cyc();
  endtask

  task automatic test_autosave;
    int first, cnt;
    autosave_en = 1'b1; cpu_we = 1'b1;
    first = -1; cnt = 0;
    for (int k = 1; k <= 140; k++) begin
      next_cyc();
      if (k == 1) cpu_we = 1'b0;
      @(negedge clk_sys);
      if (ioctl_upload_req) begin cnt++; if (first < 0) first = k; end
    end
    next_cyc();
    $display("autosave first_pulse=%0d pulses=%0d", first, cnt);
    n_cmp++; if (first != 100) begin n_bad++; $display("FAIL autosave_delay got %0d want 100", first); end
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL autosave_count got %0d want 1", cnt); end
    cpu_we = 1'b1;
    first = -1; cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      next_cyc();
      if (k == 1) cpu_we = 1'b0;
      if (k == 50) cpu_we = 1'b1;
      if (k == 51) cpu_we = 1'b0;
      @(negedge clk_sys);
      if (ioctl_upload_req) begin cnt++; if (first < 0) first = k; end
    end
    next_cyc();
    $display("autosave restart first_pulse=%0d pulses=%0d", first, cnt);
    n_cmp++; if (first != 150) begin n_bad++; $display("FAIL autosave_restart got %0d want 150", first); end
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL autosave_restart_count got %0d want 1", cnt); end
    autosave_en = 1'b0;
    next_cyc();
  endtask

  task automatic test_save_pending;
    int cnt;
    logic p0, p1, p2;
    ioctl_upload = 1'b1; next_cyc();
    save_req = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      if (ioctl_upload_req) cnt++;
      next_cyc();
    end
    n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL save_during_upload got %0d pulses want 0", cnt); end
    ioctl_upload = 1'b0;
    @(negedge clk_sys); p0 = ioctl_upload_req; next_cyc();
    @(negedge clk_sys); p1 = ioctl_upload_req; next_cyc();
    @(negedge clk_sys); p2 = ioctl_upload_req; next_cyc();
    $display("save pending pulses=%b%b%b", p0, p1, p2);
    n_cmp++; if ({p0, p1, p2} !== 3'b010) begin n_bad++; $display("FAIL save_pending got %b%b%b want 010", p0, p1, p2); end
    save_req = 1'b0; next_cyc();
    save_req = 1'b1;
    @(negedge clk_sys); p0 = ioctl_upload_req; next_cyc();
    @(negedge clk_sys); p1 = ioctl_upload_req; next_cyc();
    @(negedge clk_sys); p2 = ioctl_upload_req; next_cyc();
    $display("save direct pulses=%b%b%b", p0, p1, p2);
    n_cmp++; if ({p0, p1, p2} !== 3'b010) begin n_bad++; $display("FAIL save_direct got %b%b%b want 010", p0, p1, p2); end
    save_req = 1'b0; next_cyc();
  endtask

  task automatic test_reset_midread;
    cpu_we = 1'b1; next_cyc(); cpu_we = 1'b0;
    ioctl_upload = 1'b1; next_cyc();
    ioctl_index = 8'd2; ioctl_rd = 1'b1; ioctl_addr = 25'h0000010;
    @(negedge clk_sys);
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL midread_accept_wait got %b want 1", ioctl_wait); end
    next_cyc();
    ioctl_rd = 1'b0; reset = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midread_busy got %b want 1", busy); end
    next_cyc();
    reset = 1'b0;
    @(negedge clk_sys);
    $display("after mid-read reset wait=%b busy=%b dirty=%b din=%h", ioctl_wait, busy, dirty, ioctl_din);
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL midread_wait got %b want 0", ioctl_wait); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midread_busy_after got %b want 0", busy); end
    n_cmp++; if (dirty !== 1'b0) begin n_bad++; $display("FAIL midread_dirty got %b want 0", dirty); end
    n_cmp++; if (ioctl_din !== 8'hFF) begin n_bad++; $display("FAIL midread_din got %h want ff", ioctl_din); end
    next_cyc();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[0]        = 8'h11;
    mem[16]       = 8'h5A;
    mem[16'h7FFE] = 8'h3C;
    mem[16'h7FFF] = 8'hC3;
    ram_q = 8'h00;
    test_reset();
    test_read_inrange();
    test_ignored();
    test_read_oor();
    test_dirty();
    test_autosave();
    test_save_pending();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
